// File: rtl/seq_det_pkg.sv
// Shared definitions for the non-overlapping serial pattern detector.
//
// Contents:
//   PAT_MAX          upper bound on the pattern length (16)
//   prog_t           progress index: number of pattern bits matched so far
//   pat_vec_t        pattern bits, reordered so bit k is the k-th bit received
//   fb_table_t       mismatch fallback table, indexed by {progress, din}
//   arrival_order()  reorders an MSB-first pattern into arrival order
//   build_fallback() builds the fallback table at elaboration time
//   CNT_W/CNT_MAX    width and saturation value of the optional match counter
package seq_det_pkg;

    localparam int PAT_MAX = 16;
    localparam int PROG_W  = $clog2(PAT_MAX);

    typedef logic [PROG_W-1:0]                 prog_t;
    typedef logic [PAT_MAX-1:0]                pat_vec_t;
    typedef logic [2*PAT_MAX-1:0][PROG_W-1:0]  fb_table_t;

    localparam int             CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Pattern parameters are written MSB-first; the FSM wants bit k to be the
    // k-th bit on the wire so it can index directly with the progress count.
    function automatic pat_vec_t arrival_order(input pat_vec_t pat, input int len);
        pat_vec_t r;
        r = '0;
        for (int k = 0; k < len; k++) begin
            r[k] = pat[len-1-k];
        end
        return r;
    endfunction

    // For every progress value p and every input bit b, find the longest
    // proper prefix of the pattern that is a suffix of (first p pattern bits
    // followed by b). Only the mismatching-bit entries are used by the FSM;
    // the matching-bit entries are filled but never selected.
    function automatic fb_table_t build_fallback(input pat_vec_t arr, input int len);
        fb_table_t tbl;
        pat_vec_t  s;
        logic      ok;
        int        best;
        tbl = '0;
        for (int p = 0; p < len; p++) begin
            for (int b = 0; b < 2; b++) begin
                s = '0;
                for (int i = 0; i < p; i++) begin
                    s[i] = arr[i];
                end
                s[p] = (b != 0);
                best = 0;
                // Ascending k: the last candidate that fits is the longest.
                for (int k = 1; k <= p; k++) begin
                    ok = 1'b1;
                    for (int j = 0; j < k; j++) begin
                        if (s[p+1-k+j] != arr[j]) ok = 1'b0;
                    end
                    if (ok) best = k;
                end
                tbl[p*2+b] = prog_t'(best);
            end
        end
        return tbl;
    endfunction

endpackage

// File: rtl/seq_det_match_counter.sv
// Saturating count of detector matches.
//
// Ports:
//   clk    clock, rising edge
//   rst    synchronous active-high reset, clears the count
//   inc_i  one-cycle match flag; counts once per rising edge while high
//   cnt_o  current count, holds at CNT_MAX once reached
module seq_det_match_counter
    import seq_det_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_detector_1011_nonovl.sv
// Mealy serial pattern detector with non-overlapping matching.
// One bit of din is consumed per clock; dout is high combinationally in the
// cycle whose din completes PATTERN. After a match all progress is dropped.
//
// Parameters:
//   PAT_LEN  pattern length, legal range 2..16
//   PATTERN  pattern bits, MSB is the first bit received
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset; forces dout low while asserted
//   din        serial input bit
//   dout       match flag (combinational from progress and din)
//   match_cnt  [7:0] saturating match count, present only when the
//              SEQ_DET_COUNT_EN macro is defined
module seq_detector_1011_nonovl
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic       dout
`ifdef SEQ_DET_COUNT_EN
    ,
    output logic [7:0] match_cnt
`endif
);

    localparam pat_vec_t  PAT_ARR  = arrival_order(pat_vec_t'(PATTERN), PAT_LEN);
    localparam fb_table_t FB_TABLE = build_fallback(PAT_ARR, PAT_LEN);
    localparam prog_t     LAST_P   = prog_t'(PAT_LEN - 1);

    prog_t p_q;
    prog_t p_d;
    logic  exp_bit;

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        p_d     = p_q;
        dout    = 1'b0;
        exp_bit = PAT_ARR[p_q];
        if (din == exp_bit) begin
            if (p_q == LAST_P) begin
                // Full match: flag it and restart from scratch (no overlap).
                p_d  = '0;
                dout = !rst;
            end else begin
                p_d = p_q + 1'b1;
            end
        end else begin
            p_d = FB_TABLE[{p_q, din}];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its inputs from before the edge. Reset takes priority, which
    // also keeps an unknown din during reset out of the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

`ifdef SEQ_DET_COUNT_EN
    seq_det_match_counter u_match_counter (
        .clk   (clk),
        .rst   (rst),
        .inc_i (dout),
        .cnt_o (match_cnt)
    );
`else
    // Counter absent in this build; detector behaviour is unchanged.
`endif

endmodule

// File: tb/tb_seq_detector_1011_nonovl.sv
module tb_seq_detector_1011_nonovl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic       dout;
`ifdef SEQ_DET_COUNT_EN
    logic [7:0] match_cnt;
`endif

    seq_detector_1011_nonovl dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .dout (dout)
`ifdef SEQ_DET_COUNT_EN
        ,
        .match_cnt (match_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        dout;
        logic [7:0]  cnt;
        int unsigned cyc;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    // Reference model state: bits received since the last reset or match.
    logic hist[$];
    logic pat_bits[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int   cnt_model   = 0;
    int   cyc         = 0;

    // Apply one cycle of stimulus and queue the expected response.
    task automatic drive(input logic r, input logic b);
        exp_t e;
        logic hit;
        @(negedge clk);
        rst = r;
        din = b;
        hit = 1'b0;
        if (r) begin
            hist.delete();
        end else begin
            hist.push_back(b);
            if (hist.size() > 4) void'(hist.pop_front());
            if (hist.size() == 4) begin
                hit = 1'b1;
                for (int i = 0; i < 4; i++)
                    if (hist[i] != pat_bits[i]) hit = 1'b0;
            end
            if (hit) hist.delete();
        end
        e.dout = hit;
        e.cnt  = 8'(cnt_model);
        e.cyc  = cyc;
        exp_q.push_back(e);
        if (r) cnt_model = 0;
        else if (hit && cnt_model < 255) cnt_model++;
        cyc++;
    endtask

    task automatic drive_seq(input logic [15:0] bits, input int n);
        logic [15:0] v;
        v = bits;
        for (int i = n - 1; i >= 0; i--) drive(1'b0, v[i]);
    endtask

    // Monitor: samples 3 ns after the falling edge, well before the next
    // rising edge, and compares against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (dout !== e.dout) begin
                    failures++;
                    $display("FAIL dout cyc=%0d got=%b exp=%b", e.cyc, dout, e.dout);
                end
`ifdef SEQ_DET_COUNT_EN
                checks++;
                if (match_cnt !== e.cnt) begin
                    failures++;
                    $display("FAIL match_cnt cyc=%0d got=%0d exp=%0d", e.cyc, match_cnt, e.cnt);
                end
`endif
            end
        end
    end

    initial begin
        int wait_cyc;
        // Reset, including an unknown din while reset is held.
        drive(1'b1, 1'b0);
        drive(1'b1, 1'bx);
        // Basic sequence: single pulse on bit 7.
        drive_seq(16'b1001_0110_0111, 12);
        drive(1'b1, 1'b0);
        // Non-overlap: pulse on bit 4 only.
        drive_seq(16'b101_1011, 7);
        drive(1'b1, 1'b0);
        // Back-to-back: pulses on bits 4 and 8.
        drive_seq(16'b1011_1011, 8);
        drive(1'b1, 1'b0);
        // Fallback from 101 on a 0 into 10, then pulse on bit 6.
        drive_seq(16'b10_1011, 6);
        drive(1'b1, 1'b0);
        // Reset while in the last state with din=1, then 0,1,1: no pulse.
        drive_seq(16'b101, 3);
        drive(1'b1, 1'b1);
        drive_seq(16'b011, 3);
        drive(1'b1, 1'b0);
`ifdef SEQ_DET_COUNT_EN
        // Saturation of the match counter, then clear by reset.
        for (int i = 0; i < 300; i++) drive_seq(16'b1011, 4);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
`endif
        // Randomized stream with occasional resets, biased toward ones so
        // matches and fallbacks are frequent.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 6));
        end
        @(negedge clk);
        rst = 1'b0;
        din = 1'b0;
        wait_cyc = 0;
        while (exp_q.size() != 0 && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        #4;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
